// File: rtl/riscv_ex_collect.sv
// EX-stage result collector: captures ALU/MUL/DIV results into a 2-entry FIFO
// and presents them in order to WB, with registered back-pressure and sticky overflow.

module riscv_ex_collect #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ex_stall,
    input  logic            id_bubble,
    input  logic [4:0]      id_rd,
    input  logic            id_is_mul,
    input  logic            id_is_div,
    input  logic            alu_bubble,
    input  logic [XLEN-1:0] alu_r,
    input  logic [4:0]      alu_rd,
    input  logic            mul_bubble,
    input  logic [XLEN-1:0] mul_r,
    input  logic            div_bubble,
    input  logic [XLEN-1:0] div_r,
    input  logic            wb_stall,
    output logic            ex_bubble,
    output logic [XLEN-1:0] ex_r,
    output logic [4:0]      ex_rd,
    output logic            collect_stall,
    output logic            collect_ovf
);

    logic [XLEN-1:0] data_r [0:1];
    logic [4:0]      rd_r   [0:1];
    logic            wr_ptr_r;
    logic            rd_ptr_r;
    logic [1:0]      count_r;
    logic [4:0]      mul_rd_r;
    logic [4:0]      div_rd_r;
    logic            stall_r;
    logic            ovf_r;

    logic            push_s;
    logic [XLEN-1:0] push_data_s;
    logic [4:0]      push_rd_s;
    logic            pop_s;
    logic            wr_en_s;
    logic            ovf_set_s;
    logic [1:0]      count_next_s;

    // Source select (mul > div > alu) plus push/pop and occupancy bookkeeping.
    always_comb begin
        push_s      = 1'b0;
        push_data_s = '0;
        push_rd_s   = 5'd0;
        if (!mul_bubble) begin
            push_s      = 1'b1;
            push_data_s = mul_r;
            push_rd_s   = mul_rd_r;
        end else if (!div_bubble) begin
            push_s      = 1'b1;
            push_data_s = div_r;
            push_rd_s   = div_rd_r;
        end else if (!alu_bubble) begin
            push_s      = 1'b1;
            push_data_s = alu_r;
            push_rd_s   = alu_rd;
        end else begin
            push_s      = 1'b0;
        end

        pop_s = (count_r != 2'd0) && !wb_stall;
        // When full, a simultaneous pop frees the head slot, which is the write slot.
        wr_en_s   = push_s && ((count_r != 2'd2) || pop_s);
        ovf_set_s = push_s && (count_r == 2'd2) && !pop_s;

        case ({wr_en_s, pop_s})
            2'b10:   count_next_s = count_r + 2'd1;
            2'b01:   count_next_s = count_r - 2'd1;
            default: count_next_s = count_r;
        endcase
    end

    // FIFO storage, pointers, latched long-latency destinations and status registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_r[0] <= '0;
            data_r[1] <= '0;
            rd_r[0]   <= 5'd0;
            rd_r[1]   <= 5'd0;
            wr_ptr_r  <= 1'b0;
            rd_ptr_r  <= 1'b0;
            count_r   <= 2'd0;
            mul_rd_r  <= 5'd0;
            div_rd_r  <= 5'd0;
            stall_r   <= 1'b0;
            ovf_r     <= 1'b0;
        end else begin
            if (wr_en_s) begin
                data_r[wr_ptr_r] <= push_data_s;
                rd_r[wr_ptr_r]   <= push_rd_s;
                wr_ptr_r         <= ~wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= ~rd_ptr_r;
            end
            if (!ex_stall && !id_bubble && id_is_mul) begin
                mul_rd_r <= id_rd;
            end
            if (!ex_stall && !id_bubble && id_is_div) begin
                div_rd_r <= id_rd;
            end
            count_r <= count_next_s;
            stall_r <= (count_next_s == 2'd2) || ((count_next_s != 2'd0) && wb_stall);
            ovf_r   <= ovf_r | ovf_set_s;
        end
    end

    assign ex_bubble     = (count_r == 2'd0);
    assign ex_r          = data_r[rd_ptr_r];
    assign ex_rd         = rd_r[rd_ptr_r];
    assign collect_stall = stall_r;
    assign collect_ovf   = ovf_r;

    riscv_ex_collect_chk #(
        .DEPTH (DEPTH)
    ) u_chk (
        .clk        (clk),
        .rst        (rst),
        .alu_bubble (alu_bubble),
        .mul_bubble (mul_bubble),
        .div_bubble (div_bubble)
    );

endmodule

// Protocol and configuration checks for riscv_ex_collect.
module riscv_ex_collect_chk #(
    parameter int DEPTH = 2
) (
    input logic clk,
    input logic rst,
    input logic alu_bubble,
    input logic mul_bubble,
    input logic div_bubble
);

    logic [2:0] src_s;

    assign src_s = {~mul_bubble, ~div_bubble, ~alu_bubble};

    if (DEPTH != 2) begin : g_bad_depth
        $error("riscv_ex_collect: DEPTH must be 2");
    end

    a_one_source: assert property (@(posedge clk) disable iff (rst)
        ((src_s & (src_s - 3'd1)) == 3'd0))
        else $error("riscv_ex_collect: more than one result source valid");

endmodule

// File: tb/tb_riscv_ex_collect.sv
// Directed self-checking bench for riscv_ex_collect.

module tb_riscv_ex_collect;

    logic        clk;
    logic        rst;
    logic        ex_stall;
    logic        id_bubble;
    logic [4:0]  id_rd;
    logic        id_is_mul;
    logic        id_is_div;
    logic        alu_bubble;
    logic [31:0] alu_r;
    logic [4:0]  alu_rd;
    logic        mul_bubble;
    logic [31:0] mul_r;
    logic        div_bubble;
    logic [31:0] div_r;
    logic        wb_stall;
    logic        ex_bubble;
    logic [31:0] ex_r;
    logic [4:0]  ex_rd;
    logic        collect_stall;
    logic        collect_ovf;

    int n_tests = 0;
    int n_fail  = 0;

    riscv_ex_collect #(.XLEN(32), .DEPTH(2)) dut (
        .clk           (clk),
        .rst           (rst),
        .ex_stall      (ex_stall),
        .id_bubble     (id_bubble),
        .id_rd         (id_rd),
        .id_is_mul     (id_is_mul),
        .id_is_div     (id_is_div),
        .alu_bubble    (alu_bubble),
        .alu_r         (alu_r),
        .alu_rd        (alu_rd),
        .mul_bubble    (mul_bubble),
        .mul_r         (mul_r),
        .div_bubble    (div_bubble),
        .div_r         (div_r),
        .wb_stall      (wb_stall),
        .ex_bubble     (ex_bubble),
        .ex_r          (ex_r),
        .ex_rd         (ex_rd),
        .collect_stall (collect_stall),
        .collect_ovf   (collect_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic is_mul, input logic [4:0] rd, input logic stall_ex);
        ex_stall  = stall_ex;
        id_bubble = 1'b0;
        id_rd     = rd;
        id_is_mul = is_mul;
        id_is_div = ~is_mul;
        step();
        ex_stall  = 1'b0;
        id_bubble = 1'b1;
        id_is_mul = 1'b0;
        id_is_div = 1'b0;
    endtask

    task automatic alu_push(input logic [31:0] r, input logic [4:0] rd);
        alu_bubble = 1'b0;
        alu_r      = r;
        alu_rd     = rd;
        step();
        alu_bubble = 1'b1;
    endtask

    task automatic mul_push(input logic [31:0] r);
        mul_bubble = 1'b0;
        mul_r      = r;
        step();
        mul_bubble = 1'b1;
    endtask

    task automatic div_push(input logic [31:0] r);
        div_bubble = 1'b0;
        div_r      = r;
        step();
        div_bubble = 1'b1;
    endtask

    initial begin
        rst = 1'b1; ex_stall = 1'b0; id_bubble = 1'b1; id_rd = 5'd0;
        id_is_mul = 1'b0; id_is_div = 1'b0;
        alu_bubble = 1'b1; alu_r = 32'd0; alu_rd = 5'd0;
        mul_bubble = 1'b1; mul_r = 32'd0; div_bubble = 1'b1; div_r = 32'd0;
        wb_stall = 1'b0;
        step();
        step();
        rst = 1'b0;
        chk("rst_bubble", {31'd0, ex_bubble}, 32'd1);
        chk("rst_r", ex_r, 32'd0);
        chk("rst_rd", {27'd0, ex_rd}, 32'd0);
        chk("rst_stall", {31'd0, collect_stall}, 32'd0);
        chk("rst_ovf", {31'd0, collect_ovf}, 32'd0);

        // Single ALU result: visible next cycle, gone the one after.
        alu_push(32'h0000_1234, 5'd5);
        chk("alu_bubble", {31'd0, ex_bubble}, 32'd0);
        chk("alu_r", ex_r, 32'h0000_1234);
        chk("alu_rd", {27'd0, ex_rd}, 32'd5);
        chk("alu_stall", {31'd0, collect_stall}, 32'd0);
        step();
        chk("alu_drain", {31'd0, ex_bubble}, 32'd1);

        // MUL result held across a 4-cycle WB stall.
        issue(1'b1, 5'd7, 1'b0);
        issue(1'b1, 5'd3, 1'b1);
        wb_stall = 1'b1;
        mul_push(32'hFFFF_FFFE);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("mul_hold_bubble%0d", i), {31'd0, ex_bubble}, 32'd0);
            chk($sformatf("mul_hold_r%0d", i), ex_r, 32'hFFFF_FFFE);
            chk($sformatf("mul_hold_rd%0d", i), {27'd0, ex_rd}, 32'd7);
            chk($sformatf("mul_hold_stall%0d", i), {31'd0, collect_stall}, 32'd1);
            if (i < 3) step();
        end
        wb_stall = 1'b0;
        step();
        chk("mul_pop", {31'd0, ex_bubble}, 32'd1);
        chk("mul_pop_stall", {31'd0, collect_stall}, 32'd0);

        // DIV path uses its own latched destination.
        issue(1'b0, 5'd9, 1'b0);
        div_push(32'h0000_DEAD);
        chk("div_r", ex_r, 32'h0000_DEAD);
        chk("div_rd", {27'd0, ex_rd}, 32'd9);
        step();
        chk("div_drain", {31'd0, ex_bubble}, 32'd1);

        // Fill both entries under stall, then overflow with a third push.
        issue(1'b1, 5'd2, 1'b0);
        wb_stall = 1'b1;
        alu_push(32'h1, 5'd1);
        mul_push(32'h2);
        chk("full_bubble", {31'd0, ex_bubble}, 32'd0);
        chk("full_head", ex_r, 32'h1);
        chk("full_stall", {31'd0, collect_stall}, 32'd1);
        chk("full_ovf0", {31'd0, collect_ovf}, 32'd0);
        alu_push(32'h3, 5'd3);
        chk("ovf_set", {31'd0, collect_ovf}, 32'd1);
        chk("ovf_head", ex_r, 32'h1);
        chk("ovf_head_rd", {27'd0, ex_rd}, 32'd1);
        wb_stall = 1'b0;
        step();
        chk("drain1_r", ex_r, 32'h2);
        chk("drain1_rd", {27'd0, ex_rd}, 32'd2);
        chk("drain1_bubble", {31'd0, ex_bubble}, 32'd0);
        step();
        chk("drain2_bubble", {31'd0, ex_bubble}, 32'd1);
        chk("ovf_sticky", {31'd0, collect_ovf}, 32'd1);

        // Reset while full and overflowed discards everything.
        wb_stall = 1'b1;
        alu_push(32'h77, 5'd7);
        alu_push(32'h88, 5'd8);
        wb_stall = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mrst_bubble", {31'd0, ex_bubble}, 32'd1);
        chk("mrst_stall", {31'd0, collect_stall}, 32'd0);
        chk("mrst_ovf", {31'd0, collect_ovf}, 32'd0);
        step();
        chk("mrst_nostale", {31'd0, ex_bubble}, 32'd1);
        mul_push(32'h55);
        chk("mrst_mulrd", {27'd0, ex_rd}, 32'd0);
        step();

        // Full FIFO with simultaneous pop and push.
        issue(1'b1, 5'd2, 1'b0);
        wb_stall = 1'b1;
        alu_push(32'h1, 5'd1);
        mul_push(32'h2);
        wb_stall = 1'b0;
        alu_push(32'h4, 5'd4);
        chk("pp_head", ex_r, 32'h2);
        chk("pp_stall", {31'd0, collect_stall}, 32'd1);
        chk("pp_ovf", {31'd0, collect_ovf}, 32'd0);
        step();
        chk("pp_next", ex_r, 32'h4);
        chk("pp_next_rd", {27'd0, ex_rd}, 32'd4);
        chk("pp_next_bubble", {31'd0, ex_bubble}, 32'd0);
        step();
        chk("pp_empty", {31'd0, ex_bubble}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
